uart_tx_arbiter: RTL and testbench

//  Shares one uart_tx instance among N_REQ byte producers (e.g. counter display, status, debug).

---
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte producers.
// A requester keeps the UART across a packet until it sends a byte marked last.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int BUSY_TIMEOUT = 16,
    localparam int IDW         = (N_REQ <= 2) ? 1 : $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic               start_trigger_o,
    output logic [7:0]         tx_data_o,
    input  logic               tx_busy_i,
    output logic [IDW-1:0]     grant_id_o,
    output logic               locked_o,
    output logic               err_timeout_o
);

    localparam int CNT_W = (BUSY_TIMEOUT <= 2) ? 1 : $clog2(BUSY_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ARB       = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic             locked_q, locked_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [7:0]       win_data;
    logic [N_REQ-1:0] ready;

    // Search starts just after the last grant; under lock only the owner qualifies.
    always_comb begin
        int cand;
        win_found = 1'b0;
        win_idx   = grant_q;
        win_data  = 8'h00;
        cand      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = int'(grant_q) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!win_found && req_valid_i[cand] &&
                (!locked_q || cand == int'(grant_q))) begin
                win_found = 1'b1;
                win_idx   = IDW'(cand);
                win_data  = req_data_i[8*cand +: 8];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        tx_data_d       = tx_data_q;
        grant_d         = grant_q;
        locked_d        = locked_q;
        cnt_d           = cnt_q;
        ready           = '0;
        start_trigger_o = 1'b0;
        err_timeout_o   = 1'b0;
        case (state_q)
            ARB: begin
                if (win_found) begin
                    ready[win_idx] = 1'b1;
                    tx_data_d      = win_data;
                    grant_d        = win_idx;
                    locked_d       = ~req_last_i[win_idx];
                    state_d        = LAUNCH;
                end
            end
            LAUNCH: begin
                start_trigger_o = 1'b1;
                cnt_d           = '0;
                state_d         = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy_i) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // The byte is dropped; the lock is released so others are not starved.
                    err_timeout_o = 1'b1;
                    locked_d      = 1'b0;
                    state_d       = ARB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy_i) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Held in reset, ARB must not acknowledge a requester.
    assign req_ready_o = ready & {N_REQ{rst_n}};
    assign tx_data_o   = tx_data_q;
    assign grant_id_o  = grant_q;
    assign locked_o    = locked_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB;
            tx_data_q <= 8'h00;
            grant_q   <= IDW'(N_REQ - 1);
            locked_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
            locked_q  <= locked_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small behavioural uart_tx (2 clocks per bit).
module tb_uart_tx_arbiter;
    localparam int N_REQ = 4;
    localparam int BT    = 16;
    localparam int IDW   = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N_REQ-1:0]   req_valid, req_last, req_ready;
    logic [8*N_REQ-1:0] req_data;
    logic               start_trigger;
    logic [7:0]         tx_data;
    logic               tx_busy;
    logic [IDW-1:0]     grant_id;
    logic               locked, err_timeout;

    int passes = 0;
    int total  = 0;
    int fails  = 0;

    logic       stub_dead;
    int         bcnt;
    logic [9:0] shreg;
    logic       txd;
    logic [9:0] rx_bits;
    logic       prev_start;
    logic [7:0] hold_data;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N_REQ), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready), .start_trigger_o(start_trigger), .tx_data_o(tx_data),
        .tx_busy_i(tx_busy), .grant_id_o(grant_id), .locked_o(locked),
        .err_timeout_o(err_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // uart_tx stand-in: busy rises the cycle after start_trigger, frame = 10 bits x 2 clocks.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy <= 1'b0;
            bcnt    <= 0;
            shreg   <= '1;
        end else if (tx_busy) begin
            bcnt <= bcnt + 1;
            if (bcnt[0]) shreg <= {1'b1, shreg[9:1]};
            if (bcnt == 19) tx_busy <= 1'b0;
        end else if (start_trigger && !stub_dead) begin
            shreg   <= {1'b1, tx_data, 1'b0};
            bcnt    <= 0;
            tx_busy <= 1'b1;
        end
    end
    assign txd = tx_busy ? shreg[0] : 1'b1;

    // Protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_busy && !bcnt[0]) rx_bits <= {txd, rx_bits[9:1]};
            chk("onehot0_ready", 32'($onehot0(req_ready)), 32'd1);
            chk("ready_and_start", 32'((|req_ready) && start_trigger), 32'd0);
            chk("start_width", 32'(prev_start && start_trigger), 32'd0);
            chk("grant_while_busy", 32'((|req_ready) && tx_busy), 32'd0);
            if (tx_busy) chk("tx_data_stable", 32'(tx_data), 32'(hold_data));
            if (start_trigger) hold_data <= tx_data;
            prev_start <= start_trigger;
        end else begin
            prev_start <= 1'b0;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_grant(input string tag, input logic [N_REQ-1:0] exp);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 200);
        chk(tag, 32'(req_ready), 32'(exp));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, at, errs;
        logic l16, l17;
        logic [N_REQ-1:0] r17;

        rst_n = 1'b0; stub_dead = 1'b0; rx_bits = '0; hold_data = '0; prev_start = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0;
        do_reset();
        @(negedge clk);
        chk("rst_grant_id", 32'(grant_id), 32'd3);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_start", 32'(start_trigger), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);

        // single byte from requester 2
        req_valid = 4'b0100; req_last = 4'b0100; req_data[23:16] = 8'h41;
        wait_grant("t1_ready", 4'b0100);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        chk("t1_start", 32'(start_trigger), 32'd1);
        chk("t1_grant", 32'(grant_id), 32'd2);
        chk("t1_tx_data", 32'(tx_data), 32'h41);
        chk("t1_locked", 32'(locked), 32'd0);
        @(negedge clk);
        chk("t1_busy_lat", 32'(tx_busy), 32'd1);
        n = 0;
        while (tx_busy && n < 100) begin @(negedge clk); n++; end
        chk("t1_serial", 32'(rx_bits), 32'h282);
        @(negedge clk);
        chk("t1_idle_locked", 32'(locked), 32'd0);
        chk("t1_idle_ready", 32'(req_ready), 32'd0);

        // fairness among 0,1,3
        do_reset();
        req_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0}; req_last = '1; req_valid = 4'b1011;
        wait_grant("t2_g0", 4'b0001);
        wait_grant("t2_g1", 4'b0010);
        wait_grant("t2_g3", 4'b1000);
        wait_grant("t2_g0b", 4'b0001);
        wait_grant("t2_g1b", 4'b0010);
        wait_grant("t2_g3b", 4'b1000);
        req_valid = '0;

        // packet lock: req1 sends 3 bytes while req0 waits
        do_reset();
        req_valid = 4'b0010; req_last = '0; req_data = '0; req_data[15:8] = 8'h51;
        wait_grant("t3_b1", 4'b0010);
        @(posedge clk); #1
        req_valid = 4'b0011; req_last = 4'b0001; req_data[15:8] = 8'h52; req_data[7:0] = 8'h50;
        @(negedge clk);
        chk("t3_locked", 32'(locked), 32'd1);
        chk("t3_tx_b1", 32'(tx_data), 32'h51);
        wait_grant("t3_b2", 4'b0010);
        @(posedge clk); #1 req_data[15:8] = 8'h53; req_last = 4'b0011;
        @(negedge clk);
        chk("t3_tx_b2", 32'(tx_data), 32'h52);
        wait_grant("t3_b3", 4'b0010);
        @(posedge clk); #1 req_valid = 4'b0001;
        @(negedge clk);
        chk("t3_unlocked", 32'(locked), 32'd0);
        chk("t3_tx_b3", 32'(tx_data), 32'h53);
        wait_grant("t3_req0", 4'b0001);
        req_valid = '0;

        // busy timeout with a dead UART
        do_reset();
        stub_dead = 1'b1;
        req_valid = 4'b1100; req_last = 4'b1000; req_data = {8'hE3, 8'hE2, 8'h00, 8'h00};
        wait_grant("t4_g2", 4'b0100);
        @(negedge clk);
        chk("t4_start", 32'(start_trigger), 32'd1);
        at = -1; errs = 0; l16 = 1'b0; l17 = 1'b1; r17 = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (err_timeout) begin
                errs++;
                if (at < 0) at = i;
            end
            if (i == 16) l16 = locked;
            if (i == 17) begin l17 = locked; r17 = req_ready; end
        end
        chk("t4_err_at", 32'(at), 32'd16);
        chk("t4_err_count", 32'(errs), 32'd1);
        chk("t4_locked_before", 32'(l16), 32'd1);
        chk("t4_locked_after", 32'(l17), 32'd0);
        chk("t4_next_req", 32'(r17), 32'b1000);
        stub_dead = 1'b0;

        // reset in the middle of a frame
        do_reset();
        req_valid = 4'b0010; req_last = '0; req_data = {8'h00, 8'h00, 8'h61, 8'h60};
        wait_grant("t5_g1", 4'b0010);
        @(posedge clk); #1 req_valid = 4'b0011;
        n = 0;
        while (!tx_busy && n < 20) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        chk("t5_busy_before", 32'(tx_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_ready", 32'(req_ready), 32'd0);
        chk("t5_start", 32'(start_trigger), 32'd0);
        chk("t5_tx_data", 32'(tx_data), 32'h00);
        chk("t5_grant", 32'(grant_id), 32'd3);
        chk("t5_locked", 32'(locked), 32'd0);
        chk("t5_err", 32'(err_timeout), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_grant("t5_req0_first", 4'b0001);
        req_valid = '0;
        repeat (30) @(negedge clk);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
